// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - control/status bundle between uart_rx_ctrl and its checker blocks
// Optional UART_RX_ERR_REPORT_EN adds the separate parity/stop error strobes.
interface uart_rx_ctrl_if #(parameter int PRESCALE_W = 6);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  dat_samp_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  deser_en;
  logic                  data_valid;
  logic                  rx_err;
`ifdef UART_RX_ERR_REPORT_EN
  logic                  rx_par_err;
  logic                  rx_stp_err;
`endif

  modport master (
    output rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
`ifdef UART_RX_ERR_REPORT_EN
    input  rx_par_err, rx_stp_err,
`endif
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
           stp_chk_en, deser_en, data_valid, rx_err
  );

  modport slave (
    input  rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
`ifdef UART_RX_ERR_REPORT_EN
    output rx_par_err, rx_stp_err,
`endif
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
           stp_chk_en, deser_en, data_valid, rx_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: start detect, oversample/bit counters, check enables, frame strobes
// Optional UART_RX_ERR_REPORT_EN adds separate sticky parity/stop error outputs.
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6
) (
  input logic           clk,
  input logic           rst,
  uart_rx_ctrl_if.slave bus
);
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [PRESCALE_W-1:0] r_p;
  logic [PRESCALE_W-1:0] r_edge;
  logic [PRESCALE_W-1:0] w_chk;
  logic [3:0]            r_bit;
  logic                  r_par;
  logic                  r_err;
  logic                  w_wrap;
  logic                  w_at_chk;
  logic                  w_load;
  logic                  w_done;
`ifdef UART_RX_ERR_REPORT_EN
  logic                  r_par_err;
  logic                  r_stp_err;
`endif

  // Check edge sits two cycles past the mid-bit sample so the sampler result has settled.
  assign w_chk    = (r_p >> 1) + PRESCALE_W'(2);
  assign w_wrap   = (r_edge == r_p - PRESCALE_W'(1));
  assign w_at_chk = (r_edge == w_chk);
  assign w_load   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && !bus.rx_in;
  assign w_done   = (r_state == ST_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (!bus.rx_in) w_next = ST_START;
      ST_START: begin
        if (bus.strt_glitch)  w_next = ST_IDLE;
        else if (w_wrap)      w_next = ST_DATA;
      end
      ST_DATA:   if (w_wrap && (r_bit == 4'd8)) w_next = r_par ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_wrap) w_next = ST_STOP;
      ST_STOP:   if (w_wrap) w_next = ST_DONE;
      ST_DONE:   w_next = bus.rx_in ? ST_IDLE : ST_START;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_p     <= '0;
      r_par   <= 1'b0;
      r_edge  <= '0;
      r_bit   <= '0;
      r_err   <= 1'b0;
`ifdef UART_RX_ERR_REPORT_EN
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_p    <= bus.prescale;
        r_par  <= bus.par_en;
        r_edge <= '0;
        r_bit  <= '0;
        r_err  <= 1'b0;
`ifdef UART_RX_ERR_REPORT_EN
        r_par_err <= 1'b0;
        r_stp_err <= 1'b0;
`endif
      end else begin
        // The stop bit ends straight into DONE, so its wrap never bumps bit_cnt.
        if ((w_next == ST_IDLE) || (w_next == ST_DONE)) begin
          r_edge <= '0;
          if (w_next == ST_IDLE) r_bit <= '0;
        end else if (w_wrap) begin
          r_edge <= '0;
          r_bit  <= r_bit + 4'd1;
        end else begin
          r_edge <= r_edge + PRESCALE_W'(1);
        end
        if ((r_state == ST_PARITY) && bus.par_err) r_err <= 1'b1;
        if ((r_state == ST_STOP) && bus.stp_err)   r_err <= 1'b1;
`ifdef UART_RX_ERR_REPORT_EN
        if ((r_state == ST_PARITY) && bus.par_err) r_par_err <= 1'b1;
        if ((r_state == ST_STOP) && bus.stp_err)   r_stp_err <= 1'b1;
`endif
      end
    end
  end

  assign bus.edge_cnt    = r_edge;
  assign bus.bit_cnt     = r_bit;
  assign bus.dat_samp_en = (r_state != ST_IDLE);
  assign bus.strt_chk_en = (r_state == ST_START)  && w_at_chk;
  assign bus.deser_en    = (r_state == ST_DATA)   && w_at_chk;
  assign bus.par_chk_en  = (r_state == ST_PARITY) && w_at_chk;
  assign bus.stp_chk_en  = (r_state == ST_STOP)   && w_at_chk;
  assign bus.data_valid  = w_done && !r_err;
  assign bus.rx_err      = w_done && r_err;
`ifdef UART_RX_ERR_REPORT_EN
  assign bus.rx_par_err  = w_done && r_par_err;
  assign bus.rx_stp_err  = w_done && r_stp_err;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl; honours UART_RX_ERR_REPORT_EN when defined
module tb_uart_rx_ctrl;
  localparam int PW = 6;

  typedef struct {
    int cyc;
    bit err;
    bit perr;
    bit serr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  int   cur_c = 6;
  int   n_strt = 0, n_deser = 0, n_par = 0, n_stp = 0;
  int   s_prev = 0, s_last = 0;
  exp_t q[$];
  exp_t e_pop;

  uart_rx_ctrl_if #(.PRESCALE_W(PW)) bus ();
  uart_rx_ctrl #(.PRESCALE_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_counts();
    n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.strt_chk_en === 1'b1) begin n_strt++;  check_eq("strt_edge",  bus.edge_cnt, cur_c); end
    if (bus.deser_en    === 1'b1) begin n_deser++; check_eq("deser_edge", bus.edge_cnt, cur_c); end
    if (bus.par_chk_en  === 1'b1) begin n_par++;   check_eq("par_edge",   bus.edge_cnt, cur_c); end
    if (bus.stp_chk_en  === 1'b1) begin n_stp++;   check_eq("stp_edge",   bus.edge_cnt, cur_c); end
    if (bus.data_valid === 1'b1 || bus.rx_err === 1'b1) begin
      s_prev = s_last;
      s_last = cyc;
      check_eq("strobe_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e_pop = q.pop_front();
        check_eq("strobe_cycle", cyc, e_pop.cyc);
        check_eq("data_valid", bus.data_valid, !e_pop.err);
        check_eq("rx_err", bus.rx_err, e_pop.err);
`ifdef UART_RX_ERR_REPORT_EN
        check_eq("rx_par_err", bus.rx_par_err, e_pop.perr);
        check_eq("rx_stp_err", bus.rx_stp_err, e_pop.serr);
`endif
      end
    end
  end

  // Called just after a rising edge with the DUT in IDLE or DONE; returns in the DONE cycle.
  task automatic drive_frame(input int p, input bit par, input logic [7:0] data,
                             input bit perr, input bit serr);
    int   nb, total, b, e;
    exp_t x;
    nb    = par ? 11 : 10;
    total = nb * p;
    cur_c = (p >> 1) + 2;
    bus.prescale = PW'(p);
    bus.par_en   = par;
    bus.rx_in    = 1'b0;
    x.cyc = cyc + 1 + total; x.err = perr | serr; x.perr = perr; x.serr = serr;
    q.push_back(x);
    reset_counts();
    for (int c = 0; c < total; c++) begin
      tick();
      b = c / p;
      e = c % p;
      if (c == 0) begin
        check_eq("start_edge", bus.edge_cnt, 0);
        check_eq("start_samp_en", bus.dat_samp_en, 1);
      end
      if (c == 1) begin
        bus.prescale = ~PW'(p);
        bus.par_en   = ~par;
      end
      if (b == 0)              bus.rx_in = 1'b0;
      else if (b <= 8)         bus.rx_in = data[b-1];
      else if (par && b == 9)  bus.rx_in = ^data;
      else                     bus.rx_in = 1'b1;
      bus.par_err = perr && par && (b == 9) && (e == cur_c + 1);
      bus.stp_err = serr && (b == nb - 1) && (e == cur_c + 1);
    end
    tick();
    bus.par_err = 1'b0;
    bus.stp_err = 1'b0;
    bus.rx_in   = 1'b1;
    check_eq("n_strt_chk", n_strt, 1);
    check_eq("n_deser", n_deser, 8);
    check_eq("n_par_chk", n_par, par);
    check_eq("n_stp_chk", n_stp, 1);
  endtask

  task automatic settle_and_check_queue();
    repeat (3) tick();
    check_eq("no_missing_strobe", q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_edge"}, bus.edge_cnt, 0);
    check_eq({tag, "_bit"}, bus.bit_cnt, 0);
    check_eq({tag, "_samp_en"}, bus.dat_samp_en, 0);
    check_eq({tag, "_pulses"}, {bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en,
                                bus.deser_en, bus.data_valid, bus.rx_err}, 0);
  endtask

  initial begin
    rst = 1'b0;
    bus.rx_in = 1'b1; bus.prescale = PW'(8); bus.par_en = 1'b0;
    bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) tick();

    drive_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0);
    settle_and_check_queue();

    // Start glitch: line low two cycles, start checker flags at cycle 7.
    cur_c = 6; bus.prescale = PW'(8); bus.par_en = 1'b0; bus.rx_in = 1'b0;
    reset_counts();
    for (int c = 0; c <= 8; c++) begin
      tick();
      if (c == 1) bus.rx_in = 1'b1;
      bus.strt_glitch = (c == 7);
    end
    check_eq("glitch_idle_samp_en", bus.dat_samp_en, 0);
    check_eq("glitch_idle_edge", bus.edge_cnt, 0);
    check_eq("glitch_n_strt_chk", n_strt, 1);
    check_eq("glitch_n_deser", n_deser, 0);
    settle_and_check_queue();

    drive_frame(8, 1'b1, 8'h3C, 1'b1, 1'b0);
    settle_and_check_queue();
    drive_frame(16, 1'b0, 8'h5A, 1'b0, 1'b1);
    settle_and_check_queue();

    drive_frame(8, 1'b0, 8'h81, 1'b0, 1'b0);
    drive_frame(8, 1'b0, 8'h7E, 1'b0, 1'b0);
    settle_and_check_queue();
    check_eq("b2b_gap", s_last - s_prev, 81);

    // Reset in the middle of a frame.
    cur_c = 6; bus.prescale = PW'(8); bus.par_en = 1'b0; bus.rx_in = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      tick();
      if (c == 1) bus.rx_in = 1'b1;
      if (c == 40) rst = 1'b0;
    end
    tick();
    check_all_zero("midreset");
    rst = 1'b1;
    settle_and_check_queue();

    drive_frame(8, 1'b1, 8'hC3, 1'b0, 1'b0);
    settle_and_check_queue();
    drive_frame(9, 1'b0, 8'h0F, 1'b0, 1'b0);
    settle_and_check_queue();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing controller for the UART receiver. It detects the falling start edge on the line and runs the oversampling edge and bit counters. It issues the single-cycle check and shift enables to the sampler, start-check, parity-check, stop-check and deserializer blocks, collects their registered error pulses and closes each frame with a `data_valid` or `rx_err` strobe.

## Interface
- `PRESCALE_W`, default 6: width of the oversampling ratio and the edge counter.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `rx_in` in 1: serial line, already synchronised; idle high.
- `prescale` in PRESCALE_W: oversampling ratio. Legal range is 8..2^PRESCALE_W-1. It is latched on leaving IDLE.
- `par_en` in 1: a parity bit is present; latched on leaving IDLE.
- `strt_glitch` in 1: registered one-cycle error pulse from the start checker.
- `par_err` in 1: registered one-cycle error pulse from the parity checker.
- `stp_err` in 1: registered one-cycle error pulse from the stop checker.
- `edge_cnt` out PRESCALE_W: oversample index within the current bit.
- `bit_cnt` out 4: current bit index. 0 = start, 1–8 = data, 9 = parity or stop, 10 = stop when parity is enabled.
- `dat_samp_en` out 1: sampler enable; high in every state except IDLE.
- `strt_chk_en` out 1: one-cycle enable for the start checker.
- `par_chk_en` out 1: one-cycle enable for the parity checker.
- `stp_chk_en` out 1: one-cycle enable for the stop checker.
- `deser_en` out 1: one-cycle shift enable for the deserializer.
- `data_valid` out 1: one-cycle strobe, frame received without error.
- `rx_err` out 1: one-cycle strobe, frame received with a parity or stop error.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- Definitions:
  - `P` is the latched `prescale`.
  - `S` = `P>>1`, the sample point.
  - `C` = `S+2`, the check edge; the sampler result is valid here.
- Edge counter:
  - Held at 0 in IDLE and DONE.
  - Otherwise increments each cycle and wraps from P-1 to 0.
  - On wrap, `bit_cnt` increments.
- IDLE:
  - Transition: `rx_in`=0 → START. P, `par_en` are latched; `edge_cnt`, `bit_cnt` and the sticky error flag are cleared.
- START:
  - `strt_chk_en`=1 at `edge_cnt`==C.
  - Transitions:
    - `strt_glitch`=1 in any cycle → IDLE. No strobe is issued.
    - Wrap with no glitch → DATA.
- DATA:
  - `deser_en`=1 at `edge_cnt`==C.
  - Transitions: after the wrap of bit 8 → PARITY if `par_en`, else STOP.
- PARITY:
  - `par_chk_en`=1 at C.
  - `par_err`=1 sets the sticky error flag.
  - Transition: wrap → STOP.
- STOP:
  - `stp_chk_en`=1 at C.
  - `stp_err`=1 sets the sticky error flag.
  - Transition: at `edge_cnt`==P-1 → DONE. There is no wrap increment here.
- DONE (one cycle):
  - Strobes: `data_valid`=!err or `rx_err`=err.
  - Transitions: `rx_in`=0 → START (back-to-back frame, latches as in IDLE); else → IDLE.
- Error pulses arriving outside their own state are ignored.
- Changes to `prescale` or `par_en` mid-frame have no effect until the next start.

## Timing
- Reset (`rst`=0 at a rising edge), all values after that edge:
  - State is IDLE.
  - Counters are 0.
  - All outputs are 0.
  - The sticky error flag is cleared.
- A reset asserted mid-frame aborts the frame with no strobe.
- All enables and strobes are registered-state decodes, each high for exactly one cycle.
- Error pulses arrive at C+1. With P≥8, C+1 ≤ P-1, so they arrive before the bit ends.
- Frame latency, counted from the first START cycle (cycle 0):
  - DONE occurs at cycle 10·P without parity, 11·P with parity.
- DONE and a new start in the same cycle: the start wins. The next cycle is START with `edge_cnt`=0.
- An odd P uses S=floor(P/2).

## Configuration
- `UART_RX_ERR_REPORT_EN`:
  - Defined: adds outputs `rx_par_err` and `rx_stp_err` (out, 1 bit each). They are separate sticky flags, presented for one cycle in DONE alongside `rx_err`, and reset to 0.
  - Undefined: the ports are absent and only the combined `rx_err` is produced.

## Test plan
- Clean frame, P=8, no parity, data 0xA5, stop=1:
  - One `deser_en` pulse per data bit, 8 in total, each at `edge_cnt`=6.
  - `data_valid`=1 at cycle 80 only; `rx_err` stays 0.
- Start glitch, P=8: `rx_in` low for 2 cycles, `strt_glitch` driven at cycle 7.
  - Return to IDLE at cycle 8.
  - No `deser_en`, no strobe.
- Parity error, P=8, `par_en`=1: `par_err` pulse at cycle 79.
  - `rx_err`=1 at cycle 88; `data_valid`=0.
  - With the macro defined: `rx_par_err`=1 and `rx_stp_err`=0.
- Stop error, P=16, no parity: `stp_err` pulse in the STOP bit.
  - `rx_err`=1 at cycle 160.
- Back-to-back frames: `rx_in`=0 in the DONE cycle.
  - START is entered next cycle with `edge_cnt`=0.
  - The second `data_valid` arrives exactly 10·P+1 cycles after the first.
- Reset: `rst`=0 at cycle 40 of a frame.
  - All outputs are 0 the next cycle.
  - No strobe; the next start edge begins a fresh frame.
